avg_pool_ctrl: RTL and testbench

AVG_POOL_CTRL -- requirements
Module: avg_pool_ctrl

---
 rtl/avg_pool_ctrl.sv | 130 +++++++++++++
 tb/tb_avg_pool_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool_ctrl.sv
// avg_pool_ctrl: sequences one pooling window through an external combinational
// FP16 adder and multiplier to produce the window average.
//   A window is captured on an in_valid/in_ready handshake. Its elements are then
//   summed one per cycle through the external adder (ACC) and scaled by RECIP
//   through the external multiplier (SCALE). The result is held in DONE until
//   out_ready is seen. No FP16 arithmetic happens in this block.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data   window input handshake and data (element k at
//                               [k*DATA_WIDTH +: DATA_WIDTH])
//   add_a/add_b/add_sum         shared floatAdd operands and result
//   mul_a/mul_b/mul_p           shared floatMult operands and result
//   out_valid/out_ready/avg_out result handshake and data
//   busy                        high whenever the controller is not in IDLE
//   win_count                   completed-window counter, wraps at 16 bits
module avg_pool_ctrl #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           SIZE       = 4,
  parameter logic [DATA_WIDTH-1:0] RECIP      = 16'h3400
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*SIZE-1:0] in_data,
  output logic [DATA_WIDTH-1:0]      add_a,
  output logic [DATA_WIDTH-1:0]      add_b,
  input  logic [DATA_WIDTH-1:0]      add_sum,
  output logic [DATA_WIDTH-1:0]      mul_a,
  output logic [DATA_WIDTH-1:0]      mul_b,
  input  logic [DATA_WIDTH-1:0]      mul_p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      avg_out,
  output logic                       busy,
  output logic [15:0]                win_count
);

  localparam int unsigned IW   = $clog2(SIZE);
  localparam int unsigned IDXW = IW + 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACC, SCALE, DONE} state_t;

  state_t                             state_q, state_d;
  logic [SIZE-1:0][DATA_WIDTH-1:0]    buf_q, buf_d;
  logic [DATA_WIDTH-1:0]              acc_q, acc_d;
  logic [IDXW-1:0]                    idx_q, idx_d;
  logic [DATA_WIDTH-1:0]              avg_q, avg_d;
  logic                               ov_q, ov_d;
  logic [15:0]                        cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    avg_d    = avg_q;
    ov_d     = ov_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    add_a    = '0;
    add_b    = '0;
    mul_a    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        add_a = buf_q[idx_q[IW-1:0]];
        add_b = acc_q;
        acc_d = add_sum;
        if (idx_q == LAST) begin
          // idx returns to 0 so it never points past the last element
          idx_d   = '0;
          state_d = SCALE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      SCALE: begin
        mul_a   = acc_q;
        avg_d   = mul_p;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      avg_q   <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      avg_q   <= avg_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_b     = RECIP;
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign avg_out   = avg_q;
  assign win_count = cnt_q;

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// tb_avg_pool_ctrl: randomized self-checking bench for avg_pool_ctrl.
//   Supplies real FP16 add/multiply units (via real arithmetic with a single
//   round-to-nearest-even) and checks results, handshake timing, operand
//   visibility, backpressure, reset behaviour and win_count wrap.
module tb_avg_pool_ctrl;
  localparam int unsigned DW   = 16;
  localparam int unsigned SIZE = 4;
  localparam logic [15:0] RECIP = 16'h3400;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [DW*SIZE-1:0] in_data;
  logic [DW-1:0]  add_a, add_b, add_sum, mul_a, mul_b, mul_p;
  logic           out_valid, out_ready, busy;
  logic [DW-1:0]  avg_out;
  logic [15:0]    win_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ov = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [15:0] res;

  avg_pool_ctrl #(.DATA_WIDTH(DW), .SIZE(SIZE), .RECIP(RECIP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
    .out_ready(out_ready), .avg_out(avg_out), .busy(busy), .win_count(win_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]);
      for (int i = 0; i < 24; i++) v = v / 2.0;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      for (int i = 0; i < e - 15; i++) v = v * 2.0;
      for (int i = 0; i < 15 - e; i++) v = v / 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real a, frac, rem;
    int  e, fi;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    frac = (a - 1.0) * 1024.0;
    fi   = int'($floor(frac));
    rem  = frac - real'(fi);
    if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
    if (fi == 1024) begin fi = 0; e++; end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0)  return {s, 15'h0000};
    return {s, e[4:0], fi[9:0]};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) * h2r(b));
  endfunction

  assign add_sum = fp_add(add_a, add_b);
  assign mul_p   = fp_mul(mul_a, mul_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_win();
    logic [63:0] w;
    for (int k = 0; k < SIZE; k++)
      w[k*DW +: DW] = {1'b0, 5'($urandom_range(12, 17)), 10'($urandom)};
    return w;
  endfunction

  // Runs one window from IDLE to the result handshake; called #1 after an edge.
  task automatic run_window(input logic [63:0] win, input int hold, input bit scramble,
                            input bit b2b, output logic [15:0] result);
    logic [15:0] part, expv;
    int t;
    int w;
    expv = 16'h0000;
    for (int k = 0; k < SIZE; k++) expv = fp_add(expv, win[k*DW +: DW]);
    expv = fp_mul(expv, RECIP);
    result = 16'h0000;
    out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = win;
    tick();
    in_valid = 1'b0;
    part = 16'h0000;
    t = 0;
    while (!out_valid && t <= SIZE + 8) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("busy", 32'(busy), 32'd1);
      if (t < SIZE) begin
        check("add_a", 32'(add_a), 32'(win[t*DW +: DW]));
        check("add_b", 32'(add_b), 32'(part));
        check("mul_a_acc", 32'(mul_a), 32'd0);
        part = fp_add(part, win[t*DW +: DW]);
      end else if (t == SIZE) begin
        check("mul_a", 32'(mul_a), 32'(part));
        check("mul_b", 32'(mul_b), 32'(RECIP));
        check("add_a_scale", 32'(add_a), 32'd0);
      end
      if (scramble) in_data = rand_win();
      if (scramble) in_valid = $urandom_range(0, 1) != 0;
      tick();
      t++;
    end
    in_valid = 1'b0;
    check("latency", 32'(t), 32'(SIZE + 1));
    if (b2b) check("spacing", 32'(cyc - last_ov), 32'(SIZE + 3));
    last_ov = cyc;
    check("avg_out", 32'(avg_out), 32'(expv));
    result = avg_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = rand_win();
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_avg", 32'(avg_out), 32'(expv));
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_ops", 32'({add_a, add_b} | 32'(mul_a)), 32'd0);
    end
    in_valid  = b2b;
    in_data   = rand_win();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("win_count", 32'(win_count), 32'(exp_cnt));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_avg"}, 32'(avg_out), 32'd0);
    check({tag, "_cnt"}, 32'(win_count), 32'd0);
    check({tag, "_ops"}, {add_a, add_b} | 32'(mul_a), 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) tick();
    check_idle_zero("in_reset");
    reset = 1'b1;
    tick();
    check_idle_zero("after_reset");

    run_window({16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 0, 1'b0, 1'b0, res);
    check("basic_2p5", 32'(res), 32'h4100);

    run_window(rand_win(), 10, 1'b0, 1'b0, res);

    run_window({4{16'h4400}}, 0, 1'b0, 1'b0, res);
    check("b2b_first", 32'(res), 32'h4400);
    run_window('0, 0, 1'b0, 1'b1, res);
    check("b2b_zero", 32'(res), 32'h0000);

    for (int i = 0; i < 3; i++) run_window(rand_win(), 0, 1'b1, 1'b0, res);
    for (int i = 0; i < 20; i++)
      run_window(rand_win(), $urandom_range(0, 3), $urandom_range(0, 1) != 0, 1'b0, res);

    // reset while idx is 2
    in_valid = 1'b1;
    in_data  = rand_win();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle_zero("mid_acc_reset");
    exp_cnt = 16'd0;
    run_window({4{16'h3C00}}, 0, 1'b0, 1'b0, res);
    check("reset_fresh", 32'(res), 32'h3C00);
    check("reset_fresh_cnt", 32'(win_count), 32'd1);

    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    tick();
    check("preload", 32'(win_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    run_window(rand_win(), 0, 1'b0, 1'b0, res);
    check("wrap", 32'(win_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
